spi_cfg_sequencer: RTL and testbench

Upstream command source for the converter SPI configuration serializer. Holds a small writable table of 24-bit register-write words and, on start, issues them in order over a valid/ready handshake. After each word it waits for the serializer's transfer-complete pulse, then holds a programmable inter-word gap so chip-select deasserts between words. Reports busy/done/error to the control logic.

---
 rtl/spi_cfg_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cfg_sequencer
// Purpose  : Command source for the converter SPI configuration serializer.
//            Holds a writable table of register-write words and, on start,
//            hands them out in order over a valid/ready handshake. After each
//            word it waits for the serializer's transfer-complete pulse and
//            then holds a programmable gap so chip-select can deassert
//            between words. Reports busy/done/err to the control logic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   tbl_wr_en    in   table write strobe (honoured only while idle)
//   tbl_wr_addr  in   table write index
//   tbl_wr_data  in   table write data
//   num_words    in   words to send, sampled when start is accepted
//   start        in   single-cycle start request
//   busy         out  sequence in progress
//   done         out  one-cycle pulse at end of sequence (normal or aborted)
//   err          out  sticky timeout flag, cleared by the next accepted start
//   word_data    out  word presented to the serializer
//   word_valid   out  word_data valid
//   word_ready   in   serializer accepts word
//   xfer_done    in   serializer pulse: word shifted out, CS released
//   word_idx     out  index of the current word
// ============================================================================
module spi_cfg_sequencer #(
   parameter int WORD_W         = 24,
   parameter int DEPTH          = 8,
   parameter int ADDR_W         = 3,
   parameter int GAP_CYCLES     = 2000,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tbl_wr_en,
   input  logic [ADDR_W-1:0] tbl_wr_addr,
   input  logic [WORD_W-1:0] tbl_wr_data,
   input  logic [ADDR_W:0]   num_words,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   input  logic              xfer_done,
   output logic [ADDR_W-1:0] word_idx
);

   // One shared counter serves both the GAP hold and the WAIT_DONE timeout,
   // so it is sized for the larger of the two. It only ever counts up to
   // (limit - 1), so clog2(limit) bits are enough and it never wraps.
   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
   localparam bit                TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? '0 :
                                                CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W:0]   DEPTH_N     = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_N       = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ONE_IDX     = ADDR_W'(1);
   localparam logic [CNT_W-1:0]  ONE_CNT     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4,
      S_FINISH    = 3'd5
   } state_t;

   state_t            state,      state_nx;
   logic [ADDR_W-1:0] idx,        idx_nx;
   logic [ADDR_W:0]   n_words,    n_words_nx;
   logic [CNT_W-1:0]  cnt,        cnt_nx;
   logic [WORD_W-1:0] data_q,     data_nx;
   logic              valid_q,    valid_nx;
   logic              err_q,      err_nx;
   logic              last_word;

   logic [WORD_W-1:0] table_mem [DEPTH];

   // ------------------------------------------------------------------------
   // Command table. Not reset: configuration written before a reset must
   // survive it. Writes are only honoured while idle so the word in flight
   // can never change underneath the serializer.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (tbl_wr_en && (state == S_IDLE)) begin
         table_mem[tbl_wr_addr] <= tbl_wr_data;
      end
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         n_words <= '0;
         cnt     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         n_words <= n_words_nx;
         cnt     <= cnt_nx;
         data_q  <= data_nx;
         valid_q <= valid_nx;
         err_q   <= err_nx;
      end
   end

   // n_words is always >= 1 once a sequence is running, so n_words - 1 is
   // a valid last index.
   assign last_word = ({1'b0, idx} == (n_words - ONE_N));

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      n_words_nx = n_words;
      cnt_nx     = cnt;
      data_nx    = data_q;
      valid_nx   = valid_q;
      err_nx     = err_q;

      case (state)
         S_IDLE: begin
            if (start) begin
               err_nx = 1'b0;
               if (num_words == '0) begin
                  // Empty sequence still reports completion.
                  state_nx = S_FINISH;
               end else begin
                  n_words_nx = (num_words > DEPTH_N) ? DEPTH_N : num_words;
                  idx_nx     = '0;
                  state_nx   = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            data_nx  = table_mem[idx];
            valid_nx = 1'b1;
            state_nx = S_ISSUE;
         end

         S_ISSUE: begin
            if (valid_q && word_ready) begin
               valid_nx = 1'b0;
               cnt_nx   = '0;
               state_nx = S_WAIT_DONE;
            end
         end

         S_WAIT_DONE: begin
            // A completion arriving on the timeout cycle still counts as
            // success.
            if (xfer_done) begin
               cnt_nx   = '0;
               state_nx = S_GAP;
            end else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) begin
               err_nx   = 1'b1;
               state_nx = S_FINISH;
            end else begin
               cnt_nx = cnt + ONE_CNT;
            end
         end

         S_GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx = '0;
               if (last_word) begin
                  state_nx = S_FINISH;
               end else begin
                  idx_nx   = idx + ONE_IDX;
                  state_nx = S_LOAD;
               end
            end else begin
               cnt_nx = cnt + ONE_CNT;
            end
         end

         S_FINISH: begin
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy       = (state == S_LOAD) || (state == S_ISSUE) ||
                       (state == S_WAIT_DONE) || (state == S_GAP);
   assign done       = (state == S_FINISH);
   assign err        = err_q;
   assign word_data  = data_q;
   assign word_valid = valid_q;
   assign word_idx   = idx;

endmodule
`default_nettype wire

// File: tb/tb_spi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cfg_sequencer
// Purpose  : Self-checking bench for spi_cfg_sequencer. A reference model of
//            the command table plus the timing rules (first word 2 cycles
//            after start, next word GAP+1 cycles after xfer_done, done GAP
//            cycles after the last xfer_done, timeout after TIMEOUT cycles)
//            predicts every observed value. Serializer behaviour (ready
//            stalls, transfer latency) and table contents are randomized.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cfg_sequencer;

   localparam int G  = 12;
   localparam int TO = 128;
   localparam int D  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tbl_wr_en = 1'b0;
   logic [2:0]  tbl_wr_addr = '0;
   logic [23:0] tbl_wr_data = '0;
   logic [3:0]  num_words = '0;
   logic        start = 1'b0;
   logic        word_ready = 1'b0;
   logic        xfer_done = 1'b0;
   logic        busy, done, err, word_valid;
   logic [23:0] word_data;
   logic [2:0]  word_idx;

   bit [23:0] model_tbl [D];
   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;
   int done_cnt = 0;

   spi_cfg_sequencer #(
      .WORD_W(24), .DEPTH(D), .ADDR_W(3), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
      .num_words(num_words), .start(start),
      .busy(busy), .done(done), .err(err),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .xfer_done(xfer_done), .word_idx(word_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && word_valid && word_ready) hs_cnt++;
      if (!rst && done) done_cnt++;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Table write; only called while the sequencer is idle.
   task automatic write_tbl(input int addr, input bit [23:0] data);
      tbl_wr_en   = 1'b1;
      tbl_wr_addr = addr[2:0];
      tbl_wr_data = data;
      step();
      tbl_wr_en   = 1'b0;
      model_tbl[addr] = data;
   endtask

   // rdy_wait < 0 / lat_in < 0 select random values; rst_word >= 0 resets
   // the DUT a few cycles into the gap after that word.
   task automatic run_sequence(input int n_req, input int rdy_wait, input int lat_in,
                               input bit disturb, input int rst_word);
      int n, steps, hs0, d0, lat, rw;
      logic [23:0] held;
      n   = (n_req > D) ? D : n_req;
      hs0 = hs_cnt;
      d0  = done_cnt;
      num_words = n_req[3:0];
      start = 1'b1;
      step();
      start = 1'b0;
      steps = 1;
      for (int i = 0; i < n; i++) begin
         while (word_valid !== 1'b1 && steps < 5000) begin
            step();
            steps++;
         end
         n_checks++;
         if (steps != ((i == 0) ? 2 : G + 1)) begin
            n_fail++;
            $display("FAIL valid_latency word %0d: got %0d cycles, expected %0d", i, steps, (i == 0) ? 2 : G + 1);
         end
         n_checks++;
         if (word_data !== model_tbl[i]) begin
            n_fail++;
            $display("FAIL word_data word %0d: got %06h, expected %06h", i, word_data, model_tbl[i]);
         end
         n_checks++;
         if (word_idx !== i[2:0]) begin
            n_fail++;
            $display("FAIL word_idx: got %0d, expected %0d", word_idx, i);
         end
         n_checks++;
         if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_err_active word %0d: got busy=%b err=%b, expected busy=1 err=0", i, busy, err);
         end
         rw   = (rdy_wait < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? rdy_wait : 0);
         held = word_data;
         for (int k = 0; k < rw; k++) begin
            step();
            n_checks++;
            if (word_valid !== 1'b1 || word_data !== held) begin
               n_fail++;
               $display("FAIL stall_hold cycle %0d: got valid=%b data=%06h, expected valid=1 data=%06h", k, word_valid, word_data, held);
            end
         end
         word_ready = 1'b1;
         step();
         word_ready = 1'b0;
         n_checks++;
         if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop word %0d: got valid=%b, expected 0", i, word_valid);
         end
         lat = (lat_in < 0) ? int'($urandom_range(1, 120)) : lat_in;
         for (int k = 1; k < lat; k++) begin
            if (disturb && i == 0 && k == 1) begin
               tbl_wr_en   = 1'b1;
               tbl_wr_addr = 3'd1;
               tbl_wr_data = 24'hFFFFFF;
               num_words   = 4'd1;
               start       = 1'b1;
            end
            step();
            tbl_wr_en = 1'b0;
            start     = 1'b0;
         end
         xfer_done = 1'b1;
         step();
         xfer_done = 1'b0;
         steps = 0;
         if (i == rst_word) begin
            repeat (3) step();
            n_checks++;
            if (busy !== 1'b1 || word_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL gap_state: got busy=%b valid=%b, expected busy=1 valid=0", busy, word_valid);
            end
            rst = 1'b1;
            step();
            rst = 1'b0;
            n_checks++;
            if ({busy, done, err, word_valid, word_idx, word_data} !== '0) begin
               n_fail++;
               $display("FAIL midseq_reset: got busy=%b done=%b err=%b valid=%b idx=%0d data=%06h, expected all 0",
                        busy, done, err, word_valid, word_idx, word_data);
            end
            repeat (G + 4) step();
            n_checks++;
            if (done_cnt != d0 || word_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_no_done: got %0d done pulses valid=%b, expected 0 pulses valid=0", done_cnt - d0, word_valid);
            end
            return;
         end
      end
      while (done !== 1'b1 && steps < 5000) begin
         step();
         steps++;
      end
      n_checks++;
      if (steps != G) begin
         n_fail++;
         $display("FAIL done_latency: got %0d cycles, expected %0d", steps, G);
      end
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0 || word_idx !== 3'(n - 1)) begin
         n_fail++;
         $display("FAIL finish_state: got busy=%b err=%b idx=%0d, expected busy=0 err=0 idx=%0d", busy, err, word_idx, n - 1);
      end
      n_checks++;
      if (hs_cnt - hs0 != n) begin
         n_fail++;
         $display("FAIL handshake_count: got %0d, expected %0d", hs_cnt - hs0, n);
      end
      step();
      n_checks++;
      if (done !== 1'b0 || done_cnt - d0 != 1 || word_idx !== 3'(n - 1)) begin
         n_fail++;
         $display("FAIL done_pulse: got done=%b pulses=%0d idx=%0d, expected done=0 pulses=1 idx=%0d",
                  done, done_cnt - d0, word_idx, n - 1);
      end
   endtask

   task automatic run_timeout;
      int steps;
      num_words = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      steps = 1;
      while (word_valid !== 1'b1 && steps < 5000) begin
         step();
         steps++;
      end
      word_ready = 1'b1;
      step();
      word_ready = 1'b0;
      steps = 0;
      while (done !== 1'b1 && steps < 5000) begin
         step();
         steps++;
      end
      n_checks++;
      if (steps != TO) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d cycles, expected %0d", steps, TO);
      end
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_flags: got err=%b busy=%b valid=%b, expected err=1 busy=0 valid=0", err, busy, word_valid);
      end
      step();
      n_checks++;
      if (done !== 1'b0 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got done=%b err=%b, expected done=0 err=1", done, err);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({busy, done, err, word_valid, word_idx, word_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got busy=%b done=%b err=%b valid=%b idx=%0d data=%06h, expected all 0",
                  busy, done, err, word_valid, word_idx, word_data);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_basic;
      write_tbl(0, 24'h000D04);
      write_tbl(1, 24'h001531);
      write_tbl(2, 24'h002134);
      run_sequence(3, 0, 100, 1'b0, -1);
   endtask

   task automatic test_ready_stall;
      run_sequence(1, 50, 40, 1'b0, -1);
   endtask

   task automatic test_timeout;
      int d0, hs0;
      run_timeout();
      d0  = done_cnt;
      hs0 = hs_cnt;
      num_words = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_words: got done=%b err=%b busy=%b valid=%b, expected done=1 err=0 busy=0 valid=0",
                  done, err, busy, word_valid);
      end
      repeat (6) step();
      n_checks++;
      if (done_cnt - d0 != 1 || hs_cnt != hs0 || word_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_words_quiet: got pulses=%0d handshakes=%0d valid=%b, expected 1 0 0",
                  done_cnt - d0, hs_cnt - hs0, word_valid);
      end
      run_timeout();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_err_clear: got err=%b, expected 0", err);
      end
      run_timeout();
      run_sequence(1, 0, 20, 1'b0, -1);
   endtask

   task automatic test_num_words_clamp;
      for (int a = 3; a < D; a++) write_tbl(a, 24'($urandom));
      run_sequence(12, -1, -1, 1'b0, -1);
   endtask

   task automatic test_busy_ignore;
      write_tbl(1, 24'h001531);
      run_sequence(2, 0, 30, 1'b1, -1);
      run_sequence(3, 0, 30, 1'b0, -1);
   endtask

   task automatic test_reset_midseq;
      run_sequence(3, 0, 50, 1'b0, 1);
      run_sequence(3, -1, -1, 1'b0, -1);
   endtask

   task automatic test_random;
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 3; w++) write_tbl(int'($urandom_range(0, D - 1)), 24'($urandom));
         run_sequence(int'($urandom_range(1, 12)), -1, -1, 1'b0, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ready_stall();
      test_timeout();
      test_num_words_clamp();
      test_busy_ignore();
      test_reset_midseq();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
